// File: rtl/pipeline_idex_hazard_reg.sv
// ID/EX pipeline register with integrated load-use hazard detection.
// Latches decoded operands and control from ID for EX one clock later. When
// the EX instruction is a load whose destination is read by the ID instruction,
// the block stalls PC and IF/ID and feeds LU_STALL bubbles into EX. A redirect
// resolved in EX (flush_IDEX) squashes the ID instruction and overrides stalls.
module pipeline_idex_hazard_reg #(
    parameter int LU_STALL = 1,   // bubbles per load-use hazard, 1..15
    parameter int CNT_W    = 16   // width of the saturating stall counter
) (
    input  logic             clk_IDEX,
    input  logic             rst_IDEX,
    input  logic             valid_ID,
    input  logic             flush_IDEX,
    input  logic [31:0]      PC_ID,
    input  logic [4:0]       Rd_addr_ID,
    input  logic [4:0]       Rs1_addr_ID,
    input  logic [4:0]       Rs2_addr_ID,
    input  logic             Rs1_used_ID,
    input  logic             Rs2_used_ID,
    input  logic [31:0]      Rs1_data_ID,
    input  logic [31:0]      Rs2_data_ID,
    input  logic [31:0]      Imm_ID,
    input  logic             ALUSrc_B_ID,
    input  logic             Branch_ID,
    input  logic             BranchN_ID,
    input  logic             MemRW_ID,
    input  logic             Jump_ID,
    input  logic             RegWrite_ID,
    input  logic [2:0]       ALU_control_ID,
    input  logic [1:0]       MemtoReg_ID,
    output logic [31:0]      PC_EX,
    output logic [4:0]       Rd_addr_EX,
    output logic [4:0]       Rs1_addr_EX,
    output logic [4:0]       Rs2_addr_EX,
    output logic             Rs1_used_EX,
    output logic             Rs2_used_EX,
    output logic [31:0]      Rs1_data_EX,
    output logic [31:0]      Rs2_data_EX,
    output logic [31:0]      Imm_EX,
    output logic             ALUSrc_B_EX,
    output logic             Branch_EX,
    output logic             BranchN_EX,
    output logic             MemRW_EX,
    output logic             Jump_EX,
    output logic             RegWrite_EX,
    output logic [2:0]       ALU_control_EX,
    output logic [1:0]       MemtoReg_EX,
    output logic             valid_EX,
    output logic             stall_IDEX,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;
    localparam logic [1:0] WB_LOAD = 2'b01;

    logic [0:0] state;
    logic [3:0] rem;
    logic       hazard;
    logic       take_id;

    // Load-use detection: a valid load in EX writing a non-zero register the ID instruction reads.
    // NOTE: always_comb assigns every output on every path, so no latch can be inferred.
    always_comb begin
        hazard = valid_EX & RegWrite_EX & (MemtoReg_EX == WB_LOAD) & (Rd_addr_EX != 5'd0) &
                 ((Rs1_used_ID & (Rs1_addr_ID == Rd_addr_EX)) |
                  (Rs2_used_ID & (Rs2_addr_ID == Rd_addr_EX))) &
                 valid_ID;
    end

    // A flush never stalls: the squashed ID slot is replaced by the redirect target.
    assign stall_IDEX = ~flush_IDEX & (hazard | (state == ST_HOLD));
    assign take_id    = (state == ST_RUN) & ~flush_IDEX & ~hazard;

    // Stall FSM: RUN passes instructions, HOLD counts down the extra load-use bubbles.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_IDEX or posedge rst_IDEX) begin
        if (rst_IDEX) begin
            state <= ST_RUN;
            rem   <= 4'd0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (!flush_IDEX && hazard && (LU_STALL > 1)) begin
                        state <= ST_HOLD;
                        rem   <= 4'(LU_STALL - 1);
                    end
                end
                ST_HOLD: begin
                    if (flush_IDEX) begin
                        state <= ST_RUN;
                        rem   <= 4'd0;
                    end else begin
                        rem <= rem - 4'd1;
                        if (rem == 4'd1) begin
                            state <= ST_RUN;
                        end
                    end
                end
                default: begin
                    state <= ST_RUN;
                    rem   <= 4'd0;
                end
            endcase
        end
    end

    // ID/EX register: latch the ID instruction, or insert a bubble by clearing valid and side-effecting controls.
    always_ff @(posedge clk_IDEX or posedge rst_IDEX) begin
        if (rst_IDEX) begin
            PC_EX          <= 32'd0;
            Rd_addr_EX     <= 5'd0;
            Rs1_addr_EX    <= 5'd0;
            Rs2_addr_EX    <= 5'd0;
            Rs1_used_EX    <= 1'b0;
            Rs2_used_EX    <= 1'b0;
            Rs1_data_EX    <= 32'd0;
            Rs2_data_EX    <= 32'd0;
            Imm_EX         <= 32'd0;
            ALUSrc_B_EX    <= 1'b0;
            Branch_EX      <= 1'b0;
            BranchN_EX     <= 1'b0;
            MemRW_EX       <= 1'b0;
            Jump_EX        <= 1'b0;
            RegWrite_EX    <= 1'b0;
            ALU_control_EX <= 3'd0;
            MemtoReg_EX    <= 2'd0;
            valid_EX       <= 1'b0;
        end else if (take_id) begin
            PC_EX          <= PC_ID;
            Rd_addr_EX     <= Rd_addr_ID;
            Rs1_addr_EX    <= Rs1_addr_ID;
            Rs2_addr_EX    <= Rs2_addr_ID;
            Rs1_used_EX    <= Rs1_used_ID;
            Rs2_used_EX    <= Rs2_used_ID;
            Rs1_data_EX    <= Rs1_data_ID;
            Rs2_data_EX    <= Rs2_data_ID;
            Imm_EX         <= Imm_ID;
            ALUSrc_B_EX    <= ALUSrc_B_ID;
            Branch_EX      <= Branch_ID;
            BranchN_EX     <= BranchN_ID;
            MemRW_EX       <= MemRW_ID;
            Jump_EX        <= Jump_ID;
            RegWrite_EX    <= RegWrite_ID;
            ALU_control_EX <= ALU_control_ID;
            MemtoReg_EX    <= MemtoReg_ID;
            valid_EX       <= valid_ID;
        end else begin
            // Data fields are don't-care in a bubble and simply hold.
            ALUSrc_B_EX    <= 1'b0;
            Branch_EX      <= 1'b0;
            BranchN_EX     <= 1'b0;
            MemRW_EX       <= 1'b0;
            Jump_EX        <= 1'b0;
            RegWrite_EX    <= 1'b0;
            ALU_control_EX <= 3'd0;
            MemtoReg_EX    <= 2'd0;
            Rs1_used_EX    <= 1'b0;
            Rs2_used_EX    <= 1'b0;
            valid_EX       <= 1'b0;
        end
    end

    // Performance counter: counts stalled cycles and sticks at all-ones.
    always_ff @(posedge clk_IDEX or posedge rst_IDEX) begin
        if (rst_IDEX) begin
            stall_cnt <= '0;
        end else if (stall_IDEX && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_idex_hazard_reg.sv
// Self-checking bench for pipeline_idex_hazard_reg. Two instances share the ID
// inputs: u_s1 (LU_STALL=1, 2-bit counter to reach saturation quickly) and
// u_s3 (LU_STALL=3). Each step drives ID, checks the combinational stall, pushes
// the expected EX contents to a scoreboard queue and pops/compares after the edge.
module tb_pipeline_idex_hazard_reg;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1a;
        logic [4:0]  rs2a;
        logic        rs1u;
        logic        rs2u;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic        alusrc;
        logic        branch;
        logic        branchn;
        logic        memrw;
        logic        jump;
        logic        regwrite;
        logic [2:0]  aluctl;
        logic [1:0]  memtoreg;
        logic        valid;
    } instr_t;

    typedef struct {
        bit     take;
        instr_t v;
        string  tag;
    } sb_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   flush = 1'b0;
    instr_t id_in = '0;
    bit     sel3 = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    sb_t exp_q[$];

    always #5 clk = ~clk;

    logic [31:0] pc1, rs1d1, rs2d1, imm1, pc3, rs1d3, rs2d3, imm3;
    logic [4:0]  rd1, rs1a1, rs2a1, rd3, rs1a3, rs2a3;
    logic        rs1u1, rs2u1, alusrc1, br1, brn1, mrw1, jmp1, rw1, v1, st1;
    logic        rs1u3, rs2u3, alusrc3, br3, brn3, mrw3, jmp3, rw3, v3, st3;
    logic [2:0]  alu1, alu3;
    logic [1:0]  m2r1, m2r3;
    logic [1:0]  cnt1;
    logic [15:0] cnt3;

    pipeline_idex_hazard_reg #(.LU_STALL(1), .CNT_W(2)) u_s1 (
        .clk_IDEX(clk), .rst_IDEX(rst), .valid_ID(id_in.valid), .flush_IDEX(flush),
        .PC_ID(id_in.pc), .Rd_addr_ID(id_in.rd), .Rs1_addr_ID(id_in.rs1a), .Rs2_addr_ID(id_in.rs2a),
        .Rs1_used_ID(id_in.rs1u), .Rs2_used_ID(id_in.rs2u), .Rs1_data_ID(id_in.rs1d),
        .Rs2_data_ID(id_in.rs2d), .Imm_ID(id_in.imm), .ALUSrc_B_ID(id_in.alusrc),
        .Branch_ID(id_in.branch), .BranchN_ID(id_in.branchn), .MemRW_ID(id_in.memrw),
        .Jump_ID(id_in.jump), .RegWrite_ID(id_in.regwrite), .ALU_control_ID(id_in.aluctl),
        .MemtoReg_ID(id_in.memtoreg),
        .PC_EX(pc1), .Rd_addr_EX(rd1), .Rs1_addr_EX(rs1a1), .Rs2_addr_EX(rs2a1),
        .Rs1_used_EX(rs1u1), .Rs2_used_EX(rs2u1), .Rs1_data_EX(rs1d1), .Rs2_data_EX(rs2d1),
        .Imm_EX(imm1), .ALUSrc_B_EX(alusrc1), .Branch_EX(br1), .BranchN_EX(brn1),
        .MemRW_EX(mrw1), .Jump_EX(jmp1), .RegWrite_EX(rw1), .ALU_control_EX(alu1),
        .MemtoReg_EX(m2r1), .valid_EX(v1), .stall_IDEX(st1), .stall_cnt(cnt1)
    );

    pipeline_idex_hazard_reg #(.LU_STALL(3), .CNT_W(16)) u_s3 (
        .clk_IDEX(clk), .rst_IDEX(rst), .valid_ID(id_in.valid), .flush_IDEX(flush),
        .PC_ID(id_in.pc), .Rd_addr_ID(id_in.rd), .Rs1_addr_ID(id_in.rs1a), .Rs2_addr_ID(id_in.rs2a),
        .Rs1_used_ID(id_in.rs1u), .Rs2_used_ID(id_in.rs2u), .Rs1_data_ID(id_in.rs1d),
        .Rs2_data_ID(id_in.rs2d), .Imm_ID(id_in.imm), .ALUSrc_B_ID(id_in.alusrc),
        .Branch_ID(id_in.branch), .BranchN_ID(id_in.branchn), .MemRW_ID(id_in.memrw),
        .Jump_ID(id_in.jump), .RegWrite_ID(id_in.regwrite), .ALU_control_ID(id_in.aluctl),
        .MemtoReg_ID(id_in.memtoreg),
        .PC_EX(pc3), .Rd_addr_EX(rd3), .Rs1_addr_EX(rs1a3), .Rs2_addr_EX(rs2a3),
        .Rs1_used_EX(rs1u3), .Rs2_used_EX(rs2u3), .Rs1_data_EX(rs1d3), .Rs2_data_EX(rs2d3),
        .Imm_EX(imm3), .ALUSrc_B_EX(alusrc3), .Branch_EX(br3), .BranchN_EX(brn3),
        .MemRW_EX(mrw3), .Jump_EX(jmp3), .RegWrite_EX(rw3), .ALU_control_EX(alu3),
        .MemtoReg_EX(m2r3), .valid_EX(v3), .stall_IDEX(st3), .stall_cnt(cnt3)
    );

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic instr_t ex_obs(input bit s3);
        instr_t r;
        if (s3) r = '{pc3, rd3, rs1a3, rs2a3, rs1u3, rs2u3, rs1d3, rs2d3, imm3,
                      alusrc3, br3, brn3, mrw3, jmp3, rw3, alu3, m2r3, v3};
        else    r = '{pc1, rd1, rs1a1, rs2a1, rs1u1, rs2u1, rs1d1, rs2d1, imm1,
                      alusrc1, br1, brn1, mrw1, jmp1, rw1, alu1, m2r1, v1};
        return r;
    endfunction

    function automatic logic [6:0] bubble_bits(input instr_t x);
        return {x.valid, x.regwrite, x.memrw, x.branch, x.branchn, x.jump, x.memtoreg};
    endfunction

    function automatic logic [15:0] cnt_obs(input bit s3);
        return s3 ? cnt3 : {14'd0, cnt1};
    endfunction

    function automatic instr_t mk(input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic u1, input logic u2,
                                  input logic rw, input logic [1:0] m2r, input logic vld);
        instr_t r;
        r.pc = pc;          r.rd = rd;           r.rs1a = rs1;        r.rs2a = rs2;
        r.rs1u = u1;        r.rs2u = u2;         r.rs1d = $urandom;   r.rs2d = $urandom;
        r.imm = $urandom;   r.alusrc = 1'($urandom);
        r.branch = 1'b0;    r.branchn = 1'b0;    r.memrw = 1'b0;      r.jump = 1'b0;
        r.regwrite = rw;    r.aluctl = 3'($urandom);
        r.memtoreg = m2r;   r.valid = vld;
        return r;
    endfunction

    // One cycle: drive ID on the falling edge, check stall, push expectation, compare after the rising edge.
    task automatic step(input string tag, input instr_t ins, input bit fl, input bit exp_stall, input bit exp_take);
        sb_t e;
        sb_t got;
        instr_t o;
        @(negedge clk);
        id_in = ins;
        flush = fl;
        #1;
        check({tag, ".stall"}, 160'(sel3 ? st3 : st1), 160'(exp_stall));
        e.take = exp_take;
        e.v    = ins;
        e.tag  = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        o = ex_obs(sel3);
        if (exp_q.size() == 0) begin
            check({tag, ".sb_underflow"}, 160'(0), 160'(1));
        end else begin
            got = exp_q.pop_front();
            if (got.take) check({got.tag, ".ex"}, 160'(o), 160'(got.v));
            else          check({got.tag, ".bubble"}, 160'(bubble_bits(o)), 160'(0));
        end
        flush = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    instr_t lw5, lw0, add6, add7, add_x0, addi_rs2, sub_rs2, add6_inv, alu5;
    logic [15:0] cnt_before;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        lw5      = mk(32'h100, 5'd5, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1);
        lw0      = mk(32'h104, 5'd0, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1);
        add6     = mk(32'h108, 5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1);
        add7     = mk(32'h10c, 5'd7, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1);
        add_x0   = mk(32'h110, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1);
        addi_rs2 = mk(32'h114, 5'd6, 5'd1, 5'd5, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1);
        sub_rs2  = mk(32'h118, 5'd8, 5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1);
        add6_inv = mk(32'h11c, 5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
        alu5     = mk(32'h120, 5'd5, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset.stall", 160'(st1), 160'(0));
        check("reset.ex_s1", 160'(ex_obs(1'b0)), 160'(0));
        check("reset.ex_s3", 160'(ex_obs(1'b1)), 160'(0));
        check("reset.cnt",   160'(cnt_obs(1'b1)), 160'(0));

        // LU_STALL=1 instance
        sel3 = 1'b0;
        step("add_pass", add7, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset between edges clears EX before the next edge.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst.ex",    160'(ex_obs(1'b0)), 160'(0));
        check("async_rst.stall", 160'(st1), 160'(0));
        @(negedge clk);
        rst = 1'b0;

        step("lu1.lw",    lw5,  1'b0, 1'b0, 1'b1);
        step("lu1.add_s", add6, 1'b0, 1'b1, 1'b0);
        step("lu1.add",   add6, 1'b0, 1'b0, 1'b1);
        check("lu1.cnt", 160'(cnt_obs(1'b0)), 160'(1));

        // Three more load-use pairs push the 2-bit counter past its maximum.
        for (int i = 0; i < 3; i++) begin
            step("sat.lw",    lw5,  1'b0, 1'b0, 1'b1);
            step("sat.add_s", add6, 1'b0, 1'b1, 1'b0);
            step("sat.add",   add6, 1'b0, 1'b0, 1'b1);
        end
        check("sat.cnt", 160'(cnt_obs(1'b0)), 160'(3));

        do_reset();
        step("x0.lw",      lw0,      1'b0, 1'b0, 1'b1);
        step("x0.add",     add_x0,   1'b0, 1'b0, 1'b1);
        step("rs2u0.lw",   lw5,      1'b0, 1'b0, 1'b1);
        step("rs2u0.addi", addi_rs2, 1'b0, 1'b0, 1'b1);
        step("rs2.lw",     lw5,      1'b0, 1'b0, 1'b1);
        step("rs2.sub_s",  sub_rs2,  1'b0, 1'b1, 1'b0);
        step("rs2.sub",    sub_rs2,  1'b0, 1'b0, 1'b1);
        step("inv.lw",     lw5,      1'b0, 1'b0, 1'b1);
        step("inv.add",    add6_inv, 1'b0, 1'b0, 1'b1);
        step("alu.prod",   alu5,     1'b0, 1'b0, 1'b1);
        step("alu.add",    add6,     1'b0, 1'b0, 1'b1);
        check("nohaz.cnt", 160'(cnt_obs(1'b0)), 160'(1));

        cnt_before = cnt_obs(1'b0);
        step("fl1.lw",  lw5,  1'b0, 1'b0, 1'b1);
        step("fl1.add", add6, 1'b1, 1'b0, 1'b0);
        step("fl1.nxt", add6, 1'b0, 1'b0, 1'b1);
        check("fl1.cnt", 160'(cnt_obs(1'b0)), 160'(cnt_before));

        // LU_STALL=3 instance
        sel3 = 1'b1;
        do_reset();
        step("lu3.lw",    lw5,  1'b0, 1'b0, 1'b1);
        step("lu3.add_a", add6, 1'b0, 1'b1, 1'b0);
        step("lu3.add_b", add6, 1'b0, 1'b1, 1'b0);
        step("lu3.add_c", add6, 1'b0, 1'b1, 1'b0);
        step("lu3.add",   add6, 1'b0, 1'b0, 1'b1);
        check("lu3.cnt", 160'(cnt_obs(1'b1)), 160'(3));

        step("fl3.lw",    lw5,  1'b0, 1'b0, 1'b1);
        step("fl3.add_s", add6, 1'b0, 1'b1, 1'b0);
        step("fl3.flush", add6, 1'b1, 1'b0, 1'b0);
        step("fl3.run",   add7, 1'b0, 1'b0, 1'b1);
        check("fl3.cnt", 160'(cnt_obs(1'b1)), 160'(4));

        // Asynchronous reset while holding returns to RUN with reset outputs.
        step("rh.lw",    lw5,  1'b0, 1'b0, 1'b1);
        step("rh.add_s", add6, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rh.stall", 160'(st3), 160'(0));
        check("rh.ex",    160'(ex_obs(1'b1)), 160'(0));
        check("rh.cnt",   160'(cnt_obs(1'b1)), 160'(0));
        @(negedge clk);
        rst = 1'b0;
        step("rh.run", add7, 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
